// File: rtl/accum_reduce_if.sv
// Operand stream in, reduction result out, status flags.
// Signals: in/in_valid/tstart, out/out_valid/out_ready, busy, err.
interface accum_reduce_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             tstart;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             err;

   modport master (
      output in, in_valid, tstart, out_ready,
      input  out, out_valid, busy, err
   );

   modport slave (
      input  in, in_valid, tstart, out_ready,
      output out, out_valid, busy, err
   );
endinterface

// File: rtl/accum_reduce.sv
// Streaming reduction: sums LEN operands per tstart-marked group.
// Ports: clk, rst (sync, active high), bus (slave side of accum_reduce_if).
module accum_reduce #(
   parameter int WIDTH = 32,
   parameter int LEN   = 8
) (
   input logic          clk,
   input logic          rst,
   accum_reduce_if.slave bus
);
   localparam int CW = $clog2(LEN + 1);

   if (LEN < 1 || LEN > 65535) begin : g_len_chk
      $error("accum_reduce: LEN out of range 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] out_r;
   logic             ov;
   logic             err_r;
   logic [WIDTH-1:0] sum;

   // Carry out of the top bit is dropped.
   assign sum = acc + bus.in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         out_r <= '0;
         ov    <= 1'b0;
         err_r <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.tstart) begin
                     acc <= bus.in;
                     cnt <= CW'(1);
                     if (LEN == 1) begin
                        out_r <= bus.in;
                        ov    <= 1'b1;
                        state <= HOLD;
                     end else begin
                        state <= ACCUM;
                     end
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (bus.in_valid) begin
                  if (bus.tstart) begin
                     // Restart: partial sum discarded.
                     err_r <= 1'b1;
                     acc   <= bus.in;
                     cnt   <= CW'(1);
                     if (LEN == 1) begin
                        out_r <= bus.in;
                        ov    <= 1'b1;
                        state <= HOLD;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                     if (cnt == CW'(LEN - 1)) begin
                        out_r <= sum;
                        ov    <= 1'b1;
                        state <= HOLD;
                     end else begin
                        acc <= sum;
                     end
                  end
               end
            end
            HOLD: begin
               if (!bus.out_ready) begin
                  if (bus.in_valid) begin
                     err_r <= 1'b1;
                  end
               end else begin
                  ov    <= 1'b0;
                  state <= IDLE;
                  // Same-cycle start keeps back-to-back groups bubble free.
                  if (bus.in_valid) begin
                     if (bus.tstart) begin
                        acc <= bus.in;
                        cnt <= CW'(1);
                        if (LEN == 1) begin
                           out_r <= bus.in;
                           ov    <= 1'b1;
                           state <= HOLD;
                        end else begin
                           state <= ACCUM;
                        end
                     end else begin
                        err_r <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out       = out_r;
   assign bus.out_valid = ov;
   assign bus.err       = err_r;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_accum_reduce.sv
// Scoreboard bench for accum_reduce with LEN=4 and LEN=2 instances.
// Expected sums are pushed at stimulus time, popped by monitors.
module tb_accum_reduce;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   accum_reduce_if #(.WIDTH(32)) b4 ();
   accum_reduce_if #(.WIDTH(32)) b2 ();

   accum_reduce #(.WIDTH(32), .LEN(4)) u4 (
      .clk(clk), .rst(rst), .bus(b4.slave)
   );
   accum_reduce #(.WIDTH(32), .LEN(2)) u2 (
      .clk(clk), .rst(rst), .bus(b2.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] q4[$];
   logic [31:0] q2[$];

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && b4.out_valid && b4.out_ready) begin
         if (q4.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL u4_extra: got %h, expected none", b4.out);
         end else begin
            chk("u4_out", b4.out, q4.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b2.out_valid && b2.out_ready) begin
         if (q2.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL u2_extra: got %h, expected none", b2.out);
         end else begin
            chk("u2_out", b2.out, q2.pop_front());
         end
      end
   end

   task automatic op4(logic v, logic ts, logic [31:0] d);
      @(posedge clk);
      #1;
      b4.in_valid = v;
      b4.tstart   = ts;
      b4.in       = d;
   endtask

   task automatic op2(logic v, logic ts, logic [31:0] d);
      @(posedge clk);
      #1;
      b2.in_valid = v;
      b2.tstart   = ts;
      b2.in       = d;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      b4.in_valid = 1'b0;
      b2.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic grp4(logic [31:0] a, logic [31:0] b,
                       logic [31:0] c, logic [31:0] d);
      op4(1, 1, a);
      op4(1, 0, b);
      op4(1, 0, c);
      op4(1, 0, d);
   endtask

   initial begin
      b4.in = '0; b4.in_valid = 0; b4.tstart = 0;
      b4.out_ready = 1;
      b2.in = '0; b2.in_valid = 0; b2.tstart = 0;
      b2.out_ready = 1;
      rst = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out", b4.out, 0);
      chk("rst_valid", {31'd0, b4.out_valid}, 0);
      chk("rst_busy", {31'd0, b4.busy}, 0);
      chk("rst_err", {31'd0, b4.err}, 0);
      chk("rst2_valid", {31'd0, b2.out_valid}, 0);
      rst = 0;

      // basic sum, one-cycle valid
      q4.push_back(32'd10);
      grp4(1, 2, 3, 4);
      op4(0, 0, 0);
      chk("t1_valid_hi", {31'd0, b4.out_valid}, 1);
      op4(0, 0, 0);
      chk("t1_valid_lo", {31'd0, b4.out_valid}, 0);
      chk("t1_popped", q4.size(), 0);
      chk("t1_err", {31'd0, b4.err}, 0);

      // wrap
      q4.push_back(32'd0);
      grp4(32'hFFFF_FFFF, 1, 0, 0);
      op4(0, 0, 0);
      op4(0, 0, 0);
      chk("t2_err", {31'd0, b4.err}, 0);

      // backpressure
      q4.push_back(32'd10);
      op4(1, 1, 1);
      b4.out_ready = 0;
      op4(1, 0, 2);
      op4(1, 0, 3);
      op4(1, 0, 4);
      for (int i = 0; i < 5; i++) begin
         op4(0, 0, 0);
         chk("t3_hold_valid", {31'd0, b4.out_valid}, 1);
         chk("t3_hold_out", b4.out, 10);
      end
      op4(1, 0, 99);
      op4(0, 0, 0);
      chk("t3_err", {31'd0, b4.err}, 1);
      chk("t3_out_kept", b4.out, 10);
      chk("t3_valid_kept", {31'd0, b4.out_valid}, 1);
      b4.out_ready = 1;
      op4(0, 0, 0);
      chk("t3_valid_lo", {31'd0, b4.out_valid}, 0);
      do_reset();
      chk("t4_pre_err", {31'd0, b4.err}, 0);

      // restart mid-group
      q4.push_back(32'd4);
      op4(1, 1, 5);
      op4(1, 0, 6);
      op4(1, 1, 1);
      op4(1, 0, 1);
      op4(1, 0, 1);
      op4(1, 0, 1);
      op4(0, 0, 0);
      op4(0, 0, 0);
      chk("t4_err", {31'd0, b4.err}, 1);

      // reset mid-group
      op4(1, 1, 7);
      op4(1, 0, 8);
      op4(0, 0, 0);
      chk("t5_busy_pre", {31'd0, b4.busy}, 1);
      do_reset();
      chk("t5_out", b4.out, 0);
      chk("t5_valid", {31'd0, b4.out_valid}, 0);
      chk("t5_busy", {31'd0, b4.busy}, 0);
      chk("t5_err", {31'd0, b4.err}, 0);
      q4.push_back(32'd10);
      grp4(1, 2, 3, 4);
      op4(0, 0, 0);
      op4(0, 0, 0);
      op4(1, 0, 5);
      op4(0, 0, 0);
      chk("t5_idle_err", {31'd0, b4.err}, 1);
      chk("t5_idle_busy", {31'd0, b4.busy}, 0);

      // LEN=2 back-to-back and gaps
      q2.push_back(32'd7);
      q2.push_back(32'd30);
      q2.push_back(32'd2);
      op2(1, 1, 3);
      op2(1, 0, 4);
      op2(1, 1, 10);
      op2(1, 0, 20);
      op2(1, 1, 1);
      op2(0, 0, 0);
      chk("t6_gap_busy", {31'd0, b2.busy}, 1);
      op2(0, 0, 0);
      op2(1, 0, 1);
      op2(0, 0, 0);
      op2(0, 0, 0);
      op2(0, 0, 0);
      chk("t6_err", {31'd0, b2.err}, 0);

      for (int i = 0; i < 20 && (q4.size() + q2.size()) != 0; i++)
         @(posedge clk);
      chk("drain", q4.size() + q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
